// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter for one shared data-memory port.
// Holds only sequencing state; sel steers the external address/data/write-enable muxes.
`default_nettype none

module mem_port_arbiter #(
  parameter int ACC_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic mem_en,
  output logic ack0,
  output logic ack1,
  output logic busy
);

  localparam logic [3:0] LAST_CNT = 4'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       sel_nx;
  logic       last, last_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      sel   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sel   <= sel_nx;
      last  <= last_nx;
    end
  end

  // sel is only re-decided on the IDLE->BUSY edge, so the owner is stable for the whole access
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel;
    last_nx  = last;
    mem_en   = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nx = BUSY;
          cnt_nx   = 4'd0;
          sel_nx   = (req0 && req1) ? ~last : req1;
        end
      end
      BUSY: begin
        mem_en = 1'b1;
        cnt_nx = cnt + 4'd1;
        if (cnt == LAST_CNT) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        ack0     = ~sel;
        ack1     = sel;
        last_nx  = sel;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy = (state != IDLE);
    gnt0 = busy & ~sel;
    gnt1 = busy & sel;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, directed corner sequences and random traffic
// checked against an access-position reference model, for ACC_CYCLES = 2 and 1.
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset, req0, req1;
  logic gnt0_a, gnt1_a, sel_a, mem_en_a, ack0_a, ack1_a, busy_a;
  logic gnt0_b, gnt1_b, sel_b, mem_en_b, ack0_b, ack1_b, busy_b;
  logic [6:0] out_a, out_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ACC_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .sel(sel_a), .mem_en(mem_en_a),
    .ack0(ack0_a), .ack1(ack1_a), .busy(busy_a)
  );

  mem_port_arbiter #(.ACC_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .sel(sel_b), .mem_en(mem_en_b),
    .ack0(ack0_b), .ack1(ack1_b), .busy(busy_b)
  );

  // output bundle order: {gnt0, gnt1, sel, mem_en, ack0, ack1, busy}
  assign out_a = {gnt0_a, gnt1_a, sel_a, mem_en_a, ack0_a, ack1_a, busy_a};
  assign out_b = {gnt0_b, gnt1_b, sel_b, mem_en_b, ack0_b, ack1_b, busy_b};

  // pos = 0 when idle, else 1-based cycle within the current access (ACC busy cycles + 1 ack cycle)
  typedef struct {
    int pos;
    bit sel;
    bit last;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t mstep(mstate_t s, bit r, bit q0, bit q1, int acc);
    mstate_t n;
    n = s;
    if (r) begin
      n.pos  = 0;
      n.sel  = 1'b0;
      n.last = 1'b1;
    end else if (s.pos == 0) begin
      if (q0 || q1) begin
        n.sel = (q0 && q1) ? !s.last : q1;
        n.pos = 1;
      end
    end else if (s.pos == acc + 1) begin
      n.last = s.sel;
      n.pos  = 0;
    end else begin
      n.pos = s.pos + 1;
    end
    return n;
  endfunction

  function automatic logic [6:0] mout(mstate_t s, int acc);
    bit act, en, done;
    act  = (s.pos != 0);
    en   = (s.pos >= 1) && (s.pos <= acc);
    done = (s.pos == acc + 1);
    return {act && !s.sel, act && s.sel, s.sel, en, done && !s.sel, done && s.sel, act};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Apply inputs, clock once, then check both DUTs against the model after the edge.
  task automatic step(input logic r, input logic q0, input logic q1);
    reset = r;
    req0  = q0;
    req1  = q1;
    @(posedge clk);
    ma = mstep(ma, r, q0, q1, 2);
    mb = mstep(mb, r, q0, q1, 1);
    #1;
    check("model_acc2", out_a, mout(ma, 2));
    check("model_acc1", out_b, mout(mb, 1));
  endtask

  typedef struct {
    logic       rst;
    logic       r0;
    logic       r1;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[15];
  logic [6:0] pat1[3];

  initial begin
    // expected = dut_a outputs in the cycle after the inputs are applied
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 7'b0000000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 7'b1001001};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 7'b1001001};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 7'b1000101};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 7'b0111001};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 7'b0111001};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 7'b0110011};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 7'b0010000};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 7'b1001001};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 7'b1001001};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 7'b1000101};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 7'b0000000};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 7'b0111001};
    pat1[0] = 7'b1001001;
    pat1[1] = 7'b1000101;
    pat1[2] = 7'b0000000;

    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].r0, tbl[i].r1);
      check("table", out_a, tbl[i].exp);
    end

    // req0 dropped after the first BUSY cycle still completes
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0); check("drop_busy1", out_a, 7'b1001001);
    step(1'b0, 1'b0, 1'b0); check("drop_busy2", out_a, 7'b1001001);
    step(1'b0, 1'b0, 1'b0); check("drop_ack",   out_a, 7'b1000101);
    step(1'b0, 1'b0, 1'b0); check("drop_idle",  out_a, 7'b0000000);

    // reset during the second BUSY cycle of a req1 access
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1); check("abort_busy1", out_a, 7'b0111001);
    step(1'b0, 1'b0, 1'b1); check("abort_busy2", out_a, 7'b0111001);
    step(1'b1, 1'b0, 1'b1); check("abort_reset", out_a, 7'b0000000);
    step(1'b0, 1'b1, 1'b1); check("abort_tie",   out_a, 7'b1001001);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1); check("abort_ack0",  out_a, 7'b1000101);

    // both held: four 4-cycle accesses alternating 0,1,0,1
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      logic       own;
      logic [6:0] e;
      own = logic'((k / 4) % 2);
      case (k % 4)
        0, 1:    e = {!own, own, own, 1'b1, 1'b0, 1'b0, 1'b1};
        2:       e = {!own, own, own, 1'b0, !own, own, 1'b1};
        default: e = {1'b0, 1'b0, own, 1'b0, 1'b0, 1'b0, 1'b0};
      endcase
      step(1'b0, 1'b1, 1'b1);
      check("alternate", out_a, e);
    end

    // ACC_CYCLES=1: req0 held, 3-cycle period
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 1'b1, 1'b0);
      check("acc1_period", out_b, pat1[k % 3]);
    end

    // random traffic, occasional reset
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
